// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered
//   Byte-wide transmit FIFO in front of an 8N1 UART shifter (LSB first,
//   idle-high line). Bytes are sent in write order. The shifter takes the
//   next byte straight from the STOP bit, so queued bytes go out with no
//   idle gap between frames.
//
// Parameters
//   CLK_FREQ    system clock frequency in Hz
//   BAUD        serial bit rate
//   BIT_CYCLES  clocks per serial bit (>= 2); defaults to CLK_FREQ/BAUD rounded
//   FIFO_DEPTH  transmit buffer depth (power of 2, >= 2)
//
// Ports
//   clk                 rising-edge clock
//   reset               synchronous, active-high reset
//   tx_data_in          byte to enqueue
//   write_tx_data       single-cycle enqueue strobe (dropped while full)
//   tx_buffer_full      FIFO holds FIFO_DEPTH bytes
//   tx_buffer_half_full FIFO holds >= FIFO_DEPTH/2 bytes
//   tx_busy             FIFO non-empty or shifter not idle
//   tx_overflow         sticky: a write was dropped while full
//   rs232_tx            serial line
module uart_tx_buffered #(
    parameter int CLK_FREQ   = 100000000,
    parameter int BAUD       = 115200,
    parameter int BIT_CYCLES = (CLK_FREQ + BAUD / 2) / BAUD,
    parameter int FIFO_DEPTH = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data_in,
    input  logic       write_tx_data,
    output logic       tx_buffer_full,
    output logic       tx_buffer_half_full,
    output logic       tx_busy,
    output logic       tx_overflow,
    output logic       rs232_tx
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(BIT_CYCLES);

    localparam logic [CW-1:0] BAUD_LAST  = CW'(BIT_CYCLES - 1);
    localparam logic [AW:0]   COUNT_FULL = (AW + 1)'(FIFO_DEPTH);
    localparam logic [AW:0]   COUNT_HALF = (AW + 1)'(FIFO_DEPTH / 2);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state, state_next;
    logic [CW-1:0] baud_cnt, baud_cnt_next;
    logic [2:0]    bit_cnt, bit_cnt_next;
    logic [7:0]    shift, shift_next;
    logic          tx_next;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, wr_ptr_next;
    logic [AW-1:0] rd_ptr, rd_ptr_next;
    logic [AW:0]   count, count_next;
    logic          push, pop, baud_done;

    // The full flag is the registered copy of count == FIFO_DEPTH, so a pop in
    // the same cycle never frees a slot for a write that arrives while full.
    assign push      = write_tx_data && !tx_buffer_full;
    assign baud_done = (baud_cnt == BAUD_LAST);

    // NOTE: every signal this block writes gets a default first; a path that
    // leaves one unassigned would infer a latch.
    always_comb begin
        state_next    = state;
        baud_cnt_next = baud_cnt;
        bit_cnt_next  = bit_cnt;
        shift_next    = shift;
        tx_next       = rs232_tx;
        pop           = 1'b0;

        case (state)
            IDLE: begin
                tx_next = 1'b1;
                if (count != '0) begin
                    pop           = 1'b1;
                    shift_next    = mem[rd_ptr];
                    bit_cnt_next  = '0;
                    baud_cnt_next = '0;
                    state_next    = START;
                    tx_next       = 1'b0;
                end
            end
            START: begin
                if (baud_done) begin
                    baud_cnt_next = '0;
                    state_next    = DATA;
                    tx_next       = shift[0];
                end else begin
                    baud_cnt_next = baud_cnt + CW'(1);
                end
            end
            DATA: begin
                if (baud_done) begin
                    baud_cnt_next = '0;
                    if (bit_cnt == 3'd7) begin
                        state_next = STOP;
                        tx_next    = 1'b1;
                    end else begin
                        shift_next   = {1'b0, shift[7:1]};
                        tx_next      = shift[1];
                        bit_cnt_next = bit_cnt + 3'd1;
                    end
                end else begin
                    baud_cnt_next = baud_cnt + CW'(1);
                end
            end
            STOP: begin
                if (baud_done) begin
                    baud_cnt_next = '0;
                    // Chain straight into the next frame when more data waits.
                    if (count != '0) begin
                        pop          = 1'b1;
                        shift_next   = mem[rd_ptr];
                        bit_cnt_next = '0;
                        state_next   = START;
                        tx_next      = 1'b0;
                    end else begin
                        state_next = IDLE;
                        tx_next    = 1'b1;
                    end
                end else begin
                    baud_cnt_next = baud_cnt + CW'(1);
                end
            end
            default: begin
                state_next    = IDLE;
                baud_cnt_next = '0;
                tx_next       = 1'b1;
            end
        endcase

        wr_ptr_next = push ? wr_ptr + AW'(1) : wr_ptr;
        rd_ptr_next = pop  ? rd_ptr + AW'(1) : rd_ptr;
        case ({push, pop})
            2'b10:   count_next = count + (AW + 1)'(1);
            2'b01:   count_next = count - (AW + 1)'(1);
            default: count_next = count;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the values from before this edge, regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state               <= IDLE;
            baud_cnt            <= '0;
            bit_cnt             <= '0;
            shift               <= '0;
            rs232_tx            <= 1'b1;
            wr_ptr              <= '0;
            rd_ptr              <= '0;
            count               <= '0;
            tx_buffer_full      <= 1'b0;
            tx_buffer_half_full <= 1'b0;
            tx_busy             <= 1'b0;
            tx_overflow         <= 1'b0;
        end else begin
            state               <= state_next;
            baud_cnt            <= baud_cnt_next;
            bit_cnt             <= bit_cnt_next;
            shift               <= shift_next;
            rs232_tx            <= tx_next;
            wr_ptr              <= wr_ptr_next;
            rd_ptr              <= rd_ptr_next;
            count               <= count_next;
            // Flags come from the next count so they update with the count itself.
            tx_buffer_full      <= (count_next == COUNT_FULL);
            tx_buffer_half_full <= (count_next >= COUNT_HALF);
            tx_busy             <= (count_next != '0) || (state_next != IDLE);
            tx_overflow         <= tx_overflow || (write_tx_data && tx_buffer_full);
        end
    end

    // NOTE: the storage array is deliberately not reset; the count and pointers
    // define which entries are valid, so stale contents are never read.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            mem[wr_ptr] <= tx_data_in;
        end
    end

endmodule

// File: doc/uart_tx_buffered.md
UART_TX_BUFFERED -- requirements
Module: uart_tx_buffered

Interface
REQ-001 Parameter CLK_FREQ, default 100000000; the system clock frequency in Hz.
REQ-002 Parameter BAUD, default 115200; the serial bit rate.
REQ-003 Parameter BIT_CYCLES, default CLK_FREQ/BAUD rounded to nearest (868); the clocks per serial bit. It SHALL be overridable and ≥ 2.
REQ-004 Parameter FIFO_DEPTH, default 16; the transmit buffer depth. It SHALL be a power of 2, ≥ 2.
REQ-005 Port clk, input, 1 bit: the single clock; all logic SHALL be on its rising edge.
REQ-006 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 Port tx_data_in, input, 8 bits: the byte to enqueue.
REQ-008 Port write_tx_data, input, 1 bit: a single-cycle enqueue strobe.
REQ-009 Port tx_buffer_full, output, 1 bit: high while the FIFO holds FIFO_DEPTH bytes.
REQ-010 Port tx_buffer_half_full, output, 1 bit: high while the FIFO holds ≥ FIFO_DEPTH/2 bytes.
REQ-011 Port tx_busy, output, 1 bit: high while the FIFO is non-empty or the shifter is not IDLE.
REQ-012 Port tx_overflow, output, 1 bit: sticky; set when a write is dropped.
REQ-013 Port rs232_tx, output, 1 bit: the serial line, 8N1, LSB first, idle high.

Function
REQ-014 All outputs SHALL be registered (no combinational input-to-output path).
REQ-015 A write SHALL be accepted iff write_tx_data=1 and tx_buffer_full=0 at that clock edge; a pop in the same cycle SHALL NOT make room for a write while full.
REQ-016 A write issued while full SHALL be discarded, set tx_overflow, and leave the FIFO contents and count unchanged.
REQ-017 FIFO occupancy SHALL be tracked by a count of width log2(FIFO_DEPTH)+1; read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-018 A simultaneous accepted write and pop SHALL leave the count unchanged.
REQ-019 The flags tx_buffer_full and tx_buffer_half_full SHALL reflect the count in the cycle after it changes.
REQ-020 The shifter states SHALL be IDLE, START, DATA, and STOP.
REQ-021 IDLE: rs232_tx=1. If the FIFO is non-empty at an edge, pop the head byte into the shift register, clear the bit counter, and go to START.
REQ-022 START: rs232_tx=0 for BIT_CYCLES clocks, then go to DATA.
REQ-023 DATA: rs232_tx=shift[0] for BIT_CYCLES clocks per bit, shift right after each bit, count 8 bits, then go to STOP.
REQ-024 STOP: rs232_tx=1 for BIT_CYCLES clocks. At its last cycle, if the FIFO is non-empty, pop and go directly to START (no idle gap); otherwise go to IDLE.
REQ-025 Latency: a byte written at edge N into an empty FIFO with the shifter IDLE SHALL be popped at edge N+1; rs232_tx SHALL go low after edge N+1.
REQ-026 The frame length SHALL be exactly 10×BIT_CYCLES clocks.
REQ-027 Bytes SHALL be transmitted in write order; none SHALL be lost or duplicated except those dropped on overflow.
REQ-028 tx_busy SHALL fall the cycle after the STOP bit of the last byte completes with the FIFO empty.

Reset
REQ-029 When reset=1 at an edge, the following SHALL take effect next cycle regardless of state:
- rs232_tx=1
- state=IDLE
- FIFO emptied (pointers and count = 0)
- tx_buffer_full=0, tx_buffer_half_full=0, tx_busy=0, tx_overflow=0
- bit and baud counters = 0
REQ-030 A reset mid-frame SHALL abort the frame; the line SHALL return high with no further bits driven.
REQ-031 A write strobe coincident with reset SHALL be ignored.

Verification (BIT_CYCLES=4, FIFO_DEPTH=4 unless noted)
REQ-032 Single byte: write 0xA5 at edge N -> rs232_tx low from N+1 for 4 clocks, then bits 1,0,1,0,0,1,0,1 (4 clocks each), then high 4 clocks; tx_busy falls at N+41.
REQ-033 Back-to-back: write 0x00, 0xFF, 0x55 on consecutive cycles -> three 40-clock frames with no idle high between the STOP bit and the next START bit; received order is 0x00, 0xFF, 0x55.
REQ-034 Overflow: write 6 bytes 0x01..0x06 on consecutive cycles -> 0x01 popped; 0x02..0x05 fill the FIFO; tx_buffer_full=1; 0x06 dropped; tx_overflow=1 and stays 1; only 0x01..0x05 are transmitted.
REQ-035 Flags: with the shifter busy, write 2 bytes -> tx_buffer_half_full=1 the cycle after the 2nd write; it falls the cycle after the next pop.
REQ-036 Reset mid-frame: assert reset during the DATA bit 3 of 0xC3 -> next cycle rs232_tx=1, tx_busy=0, tx_overflow=0, FIFO empty; a subsequent write of 0x3C transmits correctly.
REQ-037 Default rate: with BIT_CYCLES=868, write 0x41 -> the start bit lasts 868 clocks and the frame lasts 8680 clocks.
